// File: rtl/gpio_pkg.sv
// Shared GPIO constants: data word width, switch block defaults
// and the sw_state field offsets used by the register read path.
package gpio_pkg;

  localparam int GPIO_DATA_W = 32;

  localparam int SW_WIDTH_DEF = 16;
  localparam int DEBOUNCE_CYCLES_DEF = 100000;

  localparam int SW_LO = 0;
  localparam int EDGE_LO = 16;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by a stability debouncer.
// Ports: clk, rst (sync, high), sw (raw), stable (debounced), change (flips now).
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  // High in the cycle whose edge will load synced into stable.
  assign change = (synced != stable) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= sw;
      synced <= meta;
      if (synced == stable) begin
        cnt <= '0;
      end else if (change) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_registers.sv
// Switch register block: debounced switches, read port, change flag, edge irq.
// Ports: clk, rst, SW, rd_en -> sw_state, rd_valid, sw_changed, irq.
// Build option: define SW_EDGE_IRQ_EN for the rising-edge capture and irq.
module switch_registers
  import gpio_pkg::*;
#(
  parameter int SW_WIDTH        = SW_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SW_WIDTH-1:0]    SW,
  input  logic                   rd_en,
  output logic [GPIO_DATA_W-1:0] sw_state,
  output logic                   rd_valid,
  output logic                   sw_changed,
  output logic                   irq
);

  logic [SW_WIDTH-1:0]    stable;
  logic [SW_WIDTH-1:0]    change;
  logic [GPIO_DATA_W-1:0] rd_word;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .sw    (SW[i]),
      .stable(stable[i]),
      .change(change[i])
    );
  end

`ifdef SW_EDGE_IRQ_EN
  logic [SW_WIDTH-1:0] edge_cap;
  logic [SW_WIDTH-1:0] rise;
  logic [SW_WIDTH-1:0] cap_next;

  // A rise in the read cycle survives the clear.
  assign rise     = change & ~stable;
  assign cap_next = (rd_en ? '0 : edge_cap) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= cap_next;
      irq      <= |cap_next;
    end
  end

  always_comb begin
    rd_word = '0;
    rd_word[SW_LO +: SW_WIDTH]   = stable;
    rd_word[EDGE_LO +: SW_WIDTH] = edge_cap;
  end
`else
  assign irq = 1'b0;

  always_comb begin
    rd_word = '0;
    rd_word[SW_LO +: SW_WIDTH] = stable;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_state   <= '0;
      rd_valid   <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) sw_state <= rd_word;
      // A change in the read cycle wins over the clear.
      sw_changed <= (|change) | (sw_changed & ~rd_en);
    end
  end

endmodule

// File: tb/tb_switch_registers.sv
// Bench for switch_registers: directed steps plus random traffic
// against a window-based reference model of the debounced switches.
module tb_switch_registers;
  import gpio_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  SW = '0;
  logic          rd_en = 1'b0;
  logic [31:0]   sw_state;
  logic          rd_valid;
  logic          sw_changed;
  logic          irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_registers #(
    .SW_WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SW(SW),
    .rd_en(rd_en),
    .sw_state(sw_state),
    .rd_valid(rd_valid),
    .sw_changed(sw_changed),
    .irq(irq)
  );

  // Reference model state.
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_cap = '0;
  logic [31:0]  m_state = '0;
  logic         m_valid = 1'b0;
  logic         m_changed = 1'b0;
  logic         m_irq = 1'b0;
  logic [W-1:0] sw_q[$];
  logic [W-1:0] win[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stable flips a bit once the synchronized input has disagreed
  // with it for the last D edges in a row.
  task automatic model_edge();
    logic [W-1:0] synced, flip, old_stable, old_cap, rose;
    if (rst) begin
      m_stable = '0; m_cap = '0; m_state = '0;
      m_valid = 1'b0; m_changed = 1'b0; m_irq = 1'b0;
      sw_q.delete();
      sw_q.push_back('0);
      sw_q.push_back('0);
      win.delete();
      return;
    end
    synced = sw_q[1];
    sw_q.push_front(SW);
    void'(sw_q.pop_back());
    win.push_front(synced);
    if (win.size() > D) void'(win.pop_back());
    flip = '0;
    if (win.size() == D) begin
      for (int i = 0; i < W; i++) begin
        bit all;
        all = 1'b1;
        foreach (win[j]) if (win[j][i] == m_stable[i]) all = 1'b0;
        flip[i] = all;
      end
    end
    old_stable = m_stable;
    old_cap = m_cap;
    m_valid = rd_en;
`ifdef SW_EDGE_IRQ_EN
    if (rd_en) m_state = {old_cap, old_stable};
`else
    if (rd_en) m_state = {16'h0, old_stable};
`endif
    m_stable = m_stable ^ flip;
    rose = flip & m_stable;
    m_changed = (flip != '0) | (m_changed & ~rd_en);
`ifdef SW_EDGE_IRQ_EN
    m_cap = (rd_en ? '0 : old_cap) | rose;
    m_irq = |m_cap;
`else
    m_irq = 1'b0;
    if (old_cap != m_cap) m_cap = old_cap;
`endif
  endtask

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("rd_valid", rd_valid, m_valid);
      chk("sw_state", sw_state, m_state);
      chk("sw_changed", sw_changed, m_changed);
      chk("irq", irq, m_irq);
    end
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset with all switches high.
    rst = 1'b1;
    SW = 16'hFFFF;
    tick(3);
    chk("rst_state", sw_state, 32'h0);
    chk("rst_changed", sw_changed, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);

    // Release: the sampling edge counts as edge 1, stable loads on edge 6.
    rst = 1'b0;
    tick(5);
    chk("rel_early", sw_changed, 1'b0);
    tick();
    chk("rel_edge6", sw_changed, 1'b1);
    rd();
`ifdef SW_EDGE_IRQ_EN
    chk("rel_read", sw_state, 32'hFFFFFFFF);
`else
    chk("rel_read", sw_state, 32'h0000FFFF);
`endif

    // Clean change to A5A5.
    SW = 16'h0000;
    tick(10);
    rd();
    SW = 16'hA5A5;
    tick(10);
    chk("clean_chg_pre", sw_changed, 1'b1);
    rd();
    chk("clean_valid", rd_valid, 1'b1);
`ifdef SW_EDGE_IRQ_EN
    chk("clean_state", sw_state, 32'hA5A5A5A5);
`else
    chk("clean_state", sw_state, 32'h0000A5A5);
`endif
    chk("clean_chg_post", sw_changed, 1'b0);
    tick();
    chk("clean_valid_1cyc", rd_valid, 1'b0);

    // Glitch shorter than the debounce window.
    SW = 16'h0000;
    tick(10);
    rd();
    rd();
    SW = 16'h0001;
    tick(3);
    SW = 16'h0000;
    tick(10);
    chk("glitch_chg", sw_changed, 1'b0);
    rd();
    chk("glitch_state", sw_state, 32'h0);

    // Read colliding with a stable change.
    SW = 16'h0001;
    tick(10);
    rd();
    rd();
    SW = 16'h0003;
    tick(5);
    rd();
    chk("coll_state", sw_state, 32'h00000001);
    chk("coll_chg", sw_changed, 1'b1);
`ifdef SW_EDGE_IRQ_EN
    chk("coll_irq", irq, 1'b1);
`endif

    // Reset mid-debounce throws away the partial count.
    SW = 16'h0000;
    tick(10);
    rd();
    rd();
    SW = 16'h0001;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(5);
    chk("rstmid_early", sw_changed, 1'b0);
    tick();
    chk("rstmid_edge6", sw_changed, 1'b1);

    // Single rising switch, edge capture and irq.
    SW = 16'h0000;
    tick(10);
    rd();
    rd();
    SW = 16'h0008;
    tick(10);
`ifdef SW_EDGE_IRQ_EN
    chk("edge_irq", irq, 1'b1);
`else
    chk("edge_irq", irq, 1'b0);
`endif
    rd();
`ifdef SW_EDGE_IRQ_EN
    chk("edge_read1", sw_state, 32'h00080008);
`else
    chk("edge_read1", sw_state, 32'h00000008);
`endif
    chk("edge_irq_clr", irq, 1'b0);
    rd();
    chk("edge_read2", sw_state, 32'h00000008);

    // Back-to-back reads.
    SW = 16'h1234;
    tick(10);
    rd();
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_valid", rd_valid, 1'b1);
      chk("b2b_state", sw_state, 32'h00001234);
    end
    rd_en = 1'b0;
    tick();
    chk("b2b_end", rd_valid, 1'b0);

    // Random traffic: held values, short glitches, reads, rare resets.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6) SW = W'($urandom);
      else if (r < 16) SW[$urandom_range(0, W - 1)] ^= 1'b1;
      rd_en = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    rd_en = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_registers.md
SWITCH_REGISTERS -- requirements
Module: switch_registers

Interface
REQ-001 Parameters SHALL be:
- SW_WIDTH, 16: number of board switch inputs.
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles needed to accept a switch change. Legal range is ≥1.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- SW  in  SW_WIDTH  raw asynchronous board switches.
- rd_en  in  1  read strobe, one-cycle pulse from the processor side.
- sw_state  out  32  read data word.
- rd_valid  out  1  one-cycle pulse qualifying sw_state.
- sw_changed  out  1  sticky flag meaning "debounced value changed since last read".
- irq  out  1  edge interrupt; present in every build.

Function
REQ-003 Each SW bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 Each bit SHALL have its own debouncer with a stable bit and a counter of width $clog2(DEBOUNCE_CYCLES+1).
- If synced ≠ stable, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 while synced ≠ stable, stable takes synced and the counter clears.
- If synced = stable, the counter clears.
REQ-005 A clean SW transition SHALL appear on stable exactly 2 + DEBOUNCE_CYCLES cycles after the SW edge is sampled.
REQ-006 A glitch shorter than DEBOUNCE_CYCLES cycles (after sync) SHALL leave stable unchanged.
REQ-007 When rd_en is high at a clock edge:
- On the next cycle, sw_state[SW_WIDTH-1:0] SHALL equal the stable vector as it was at that edge.
- On the same next cycle, rd_valid SHALL be 1 for exactly one cycle.
REQ-008 sw_state SHALL hold its value between reads.
REQ-009 sw_state bits [31:SW_WIDTH] SHALL be 0, except for the bits defined in REQ-016.
REQ-010 Back-to-back rd_en SHALL produce back-to-back rd_valid pulses, each with fresh data.
REQ-011 sw_changed SHALL set on any cycle in which any stable bit changes.
REQ-012 sw_changed SHALL clear on a cycle with rd_en.
REQ-013 If a stable change and rd_en occur in the same cycle, sw_changed SHALL end up set (set wins).

Reset
REQ-014 While rst is high, the following SHALL be 0 at the next edge:
- synchronizers, stable vector and counters;
- sw_state, rd_valid, sw_changed, irq;
- edge-capture register.
REQ-015 Reset asserted mid-debounce SHALL discard any partial count.
- After rst falls, a high SW SHALL require the full 2 + DEBOUNCE_CYCLES latency to appear.

Configuration
REQ-016 Macro SW_EDGE_IRQ_EN defined:
- A sticky SW_WIDTH-bit edge_cap register SHALL set bit i on a 0→1 transition of stable[i].
- irq SHALL equal |edge_cap, registered.
- On rd_en, sw_state[16+SW_WIDTH-1:16] SHALL return edge_cap (SW_WIDTH ≤ 16 required), and the reported bits SHALL clear.
- An edge arriving in the same cycle as rd_en SHALL remain set.
REQ-017 Macro SW_EDGE_IRQ_EN undefined:
- No edge_cap register SHALL exist.
- irq SHALL be tied to 0.
- sw_state[31:SW_WIDTH] SHALL be 0.

Structure
REQ-018 A shared package gpio_pkg SHALL hold:
- GPIO_DATA_W = 32, the data word width shared with the LED register block;
- the default SW_WIDTH and DEBOUNCE_CYCLES constants;
- the sw_state field offsets (SW_LO = 0, EDGE_LO = 16).
REQ-019 The per-bit synchronizer plus debouncer SHALL be the sub-module debounce_bit, instantiated SW_WIDTH times in a generate loop.
REQ-020 The top level SHALL contain only the read path, the sw_changed logic and the optional edge/irq logic.

Verification (DEBOUNCE_CYCLES = 4, SW_WIDTH = 16)
REQ-021 Reset: rst high 3 cycles with SW = 16'hFFFF → sw_state = 0, sw_changed = 0, irq = 0. After release, stable = 16'hFFFF exactly 6 cycles after the first sampled edge.
REQ-022 Clean change: SW 16'h0000 → 16'hA5A5 held 10 cycles, then rd_en pulse → rd_valid one cycle with sw_state = 32'h0000A5A5. sw_changed reads 1 before rd_en and 0 after.
REQ-023 Glitch: SW[0] high for 3 cycles, then low → stable[0] stays 0, sw_changed stays 0.
REQ-024 Collision: rd_en asserted in the same cycle stable changes 16'h0001 → 16'h0003 → read returns 32'h00000001 and sw_changed remains 1.
REQ-025 With SW_EDGE_IRQ_EN: SW[3] rises and debounces → irq = 1. rd_en → sw_state = 32'h00080008, irq = 0 the cycle after. A second rd_en with no new edge → sw_state = 32'h00000008.
REQ-026 Back-to-back reads: rd_en held high 3 cycles while SW is stable at 16'h1234 → three consecutive rd_valid pulses, each with sw_state = 32'h00001234.
